arith_unit: RTL

Arithmetic execution stage of the structural ALU, directly downstream of the function decoder. It consumes the decoder's arithmetic enable plus the low ALU function bits and performs ADD/SUB/MUL in one clock. DIV runs as a WIDTH-cycle sequential restoring divider. Results are registered and qualified by a one-cycle valid pulse for the ALU output mux.

---
 rtl/arith_unit.sv | 139 +++++++++++++
 1 files changed

// File: rtl/arith_unit.sv
// Arithmetic stage: one-cycle ADD/SUB/MUL plus a WIDTH-cycle restoring divider.
// Ports:
//   CLK_ARITH         clock, rising edge
//   RST_ARITH         synchronous active-low reset
//   A_ARITH, B_ARITH  unsigned operands (dividend, divisor for DIV)
//   ALU_FUN_ARITH     00 ADD, 01 SUB, 10 MUL, 11 DIV
//   ARITH_EN_ARITH    command strobe, taken when not busy
//   ARITH_OUT_ARITH   registered 2*WIDTH result
//   CARRY_OUT_ARITH   ADD carry / SUB borrow
//   DIV_ZERO_ARITH    DIV result had a zero divisor
//   ARITH_FLAG_ARITH  one-cycle result valid pulse
//   BUSY_ARITH        division iterating
module arith_unit #(
   parameter int WIDTH = 8
) (
   input  logic                 CLK_ARITH,
   input  logic                 RST_ARITH,
   input  logic [WIDTH-1:0]     A_ARITH,
   input  logic [WIDTH-1:0]     B_ARITH,
   input  logic [1:0]           ALU_FUN_ARITH,
   input  logic                 ARITH_EN_ARITH,
   output logic [2*WIDTH-1:0]   ARITH_OUT_ARITH,
   output logic                 CARRY_OUT_ARITH,
   output logic                 DIV_ZERO_ARITH,
   output logic                 ARITH_FLAG_ARITH,
   output logic                 BUSY_ARITH
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic {
      IDLE,
      DIV_RUN
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_dvd;
   logic [WIDTH-1:0] r_dvs;
   logic [WIDTH-1:0] r_rem;
   logic [CW-1:0]    r_cnt;

   logic [WIDTH:0]     w_sum;
   logic [WIDTH:0]     w_dif;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH:0]     w_shift;
   logic               w_ge;
   logic [WIDTH-1:0]   w_trial;
   logic [WIDTH-1:0]   w_rem_nx;
   logic [WIDTH-1:0]   w_quo_nx;
   logic               w_last;

   assign w_sum  = {1'b0, A_ARITH} + {1'b0, B_ARITH};
   // Bit WIDTH of the extended difference is the borrow (A < B).
   assign w_dif  = {1'b0, A_ARITH} - {1'b0, B_ARITH};
   assign w_prod = {{WIDTH{1'b0}}, A_ARITH} * {{WIDTH{1'b0}}, B_ARITH};

   // Restoring step. The dividend register shifts out its MSB into the
   // remainder and takes the new quotient bit at its LSB, so after WIDTH
   // steps it holds the quotient. Remainder < divisor keeps the trial
   // difference within WIDTH bits whenever it is taken.
   assign w_shift  = {r_rem, r_dvd[WIDTH-1]};
   assign w_ge     = (w_shift >= {1'b0, r_dvs});
   assign w_trial  = w_shift[WIDTH-1:0] - r_dvs;
   assign w_rem_nx = w_ge ? w_trial : w_shift[WIDTH-1:0];
   assign w_quo_nx = {r_dvd[WIDTH-2:0], w_ge};
   assign w_last   = (r_cnt == CW'(WIDTH - 1));

   always_ff @(posedge CLK_ARITH) begin
      if (!RST_ARITH) begin
         r_state          <= IDLE;
         r_dvd            <= '0;
         r_dvs            <= '0;
         r_rem            <= '0;
         r_cnt            <= '0;
         ARITH_OUT_ARITH  <= '0;
         CARRY_OUT_ARITH  <= 1'b0;
         DIV_ZERO_ARITH   <= 1'b0;
         ARITH_FLAG_ARITH <= 1'b0;
         BUSY_ARITH       <= 1'b0;
      end else begin
         ARITH_FLAG_ARITH <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (ARITH_EN_ARITH) begin
                  unique case (ALU_FUN_ARITH)
                     2'b00: begin
                        ARITH_OUT_ARITH  <= {{(WIDTH-1){1'b0}}, w_sum};
                        CARRY_OUT_ARITH  <= w_sum[WIDTH];
                        DIV_ZERO_ARITH   <= 1'b0;
                        ARITH_FLAG_ARITH <= 1'b1;
                     end
                     2'b01: begin
                        ARITH_OUT_ARITH  <= {{WIDTH{1'b0}}, w_dif[WIDTH-1:0]};
                        CARRY_OUT_ARITH  <= w_dif[WIDTH];
                        DIV_ZERO_ARITH   <= 1'b0;
                        ARITH_FLAG_ARITH <= 1'b1;
                     end
                     2'b10: begin
                        ARITH_OUT_ARITH  <= w_prod;
                        CARRY_OUT_ARITH  <= 1'b0;
                        DIV_ZERO_ARITH   <= 1'b0;
                        ARITH_FLAG_ARITH <= 1'b1;
                     end
                     2'b11: begin
                        if (B_ARITH == '0) begin
                           ARITH_OUT_ARITH  <= {A_ARITH, {WIDTH{1'b1}}};
                           CARRY_OUT_ARITH  <= 1'b0;
                           DIV_ZERO_ARITH   <= 1'b1;
                           ARITH_FLAG_ARITH <= 1'b1;
                        end else begin
                           r_dvd      <= A_ARITH;
                           r_dvs      <= B_ARITH;
                           r_rem      <= '0;
                           r_cnt      <= '0;
                           BUSY_ARITH <= 1'b1;
                           r_state    <= DIV_RUN;
                        end
                     end
                  endcase
               end
            end
            DIV_RUN: begin
               r_rem <= w_rem_nx;
               r_dvd <= w_quo_nx;
               r_cnt <= r_cnt + 1'b1;
               if (w_last) begin
                  ARITH_OUT_ARITH  <= {w_rem_nx, w_quo_nx};
                  CARRY_OUT_ARITH  <= 1'b0;
                  DIV_ZERO_ARITH   <= 1'b0;
                  ARITH_FLAG_ARITH <= 1'b1;
                  BUSY_ARITH       <= 1'b0;
                  r_state          <= IDLE;
               end
            end
         endcase
      end
   end

endmodule
